// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode tags, width default and result-stage state type
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    // Result-stage FIFO occupancy doubles as its state
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - upstream/downstream valid-ready bundle of the ALU result stage
interface alu_result_stage_if #(
    parameter int size = 16,
    parameter int opw  = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] in_data;
    logic [opw-1:0]  in_op;
    logic            out_valid;
    logic            out_ready;
    logic [size-1:0] out_data;
    logic [opw-1:0]  out_op;
    logic            out_zero;
    logic            out_neg;
    logic            out_parity;

    // Stage side: accepts gate results, presents the head entry
    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op, out_zero, out_neg, out_parity
    );

    // Environment side: produces gate results, consumes the head entry
    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op, out_zero, out_neg, out_parity
    );
endinterface

// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - combinational zero/negative/parity flags of a result word
module alu_flags
    import alu_pkg::*;
#(
    parameter int size = ALU_W
) (
    input  logic [size-1:0] data_i,
    output logic            zero_o,
    output logic            neg_o,
    output logic            parity_o
);

    // Flags are pure functions of the word being pushed
    always_comb begin
        zero_o   = (data_i == '0);
        neg_o    = data_i[size-1];
        parity_o = ^data_i;
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry registered skid FIFO with status flags behind the ALU gates
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int size = ALU_W,
    parameter int opw  = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_stage_if.slave  bus,
    output logic [15:0]        res_count
);

    typedef struct packed {
        logic [size-1:0] data;
        logic [opw-1:0]  op;
        logic            zero;
        logic            neg;
        logic            parity;
    } entry_t;

    occ_state_e  state_q, state_d;
    entry_t      mem_q [2];
    logic        wr_q, rd_q;
    logic [15:0] res_count_q;

    logic   push, pop;
    logic   flag_zero, flag_neg, flag_parity;
    entry_t new_entry;
    entry_t head;

    alu_flags #(.size(size)) u_flags (
        .data_i   (bus.in_data),
        .zero_o   (flag_zero),
        .neg_o    (flag_neg),
        .parity_o (flag_parity)
    );

    // Handshake strobes; ready/valid derive from registered state only
    always_comb begin
        bus.in_ready  = (state_q != OCC_FULL);
        bus.out_valid = (state_q != OCC_EMPTY);
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
        new_entry     = '{data: bus.in_data, op: bus.in_op, zero: flag_zero,
                          neg: flag_neg, parity: flag_parity};
    end

    // Occupancy next-state from push/pop
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (push) state_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      state_d = OCC_FULL;
                else if (pop && !push) state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
        endcase
    end

    // State, pointers and delivered-result counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            res_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (push) wr_q <= ~wr_q;
            if (pop) begin
                rd_q        <= ~rd_q;
                res_count_q <= res_count_q + 16'd1;
            end
        end
    end

    // Entry storage; written only on an accepted push so idle X never lands here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q] <= new_entry;
        end
    end

    // Head entry drives the outputs, forced to zero while empty
    always_comb begin
        head           = bus.out_valid ? mem_q[rd_q] : '0;
        bus.out_data   = head.data;
        bus.out_op     = head.op;
        bus.out_zero   = head.zero;
        bus.out_neg    = head.neg;
        bus.out_parity = head.parity;
        res_count      = res_count_q;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] res_count;
    int          n_tests;
    int          n_fail;

    alu_result_stage_if #(.size(16), .opw(2)) bus ();

    alu_result_stage #(.size(16), .opw(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_op     = OP_AND;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_res_count", res_count, 0);
        chk("rst_out_data", bus.out_data, 0);

        // Single result, 1-cycle latency
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0040;
        bus.in_op     = OP_AND;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hxxxx;
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 16'h0040);
        chk("t1_out_op", bus.out_op, OP_AND);
        chk("t1_zero", bus.out_zero, 0);
        chk("t1_neg", bus.out_neg, 0);
        chk("t1_parity", bus.out_parity, 1);
        @(negedge clk);
        chk("t1_drained", bus.out_valid, 0);
        chk("t1_res_count", res_count, 1);

        // Fill under backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0000;
        bus.in_op     = OP_OR;
        @(negedge clk);
        bus.in_data = 16'h8001;
        bus.in_op   = OP_XOR;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t2_full_in_ready", bus.in_ready, 0);
        chk("t2_head_data", bus.out_data, 16'h0000);
        chk("t2_head_zero", bus.out_zero, 1);
        chk("t2_head_op", bus.out_op, OP_OR);
        @(negedge clk);
        chk("t2_hold_data", bus.out_data, 16'h0000);
        chk("t2_hold_op", bus.out_op, OP_OR);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_second_data", bus.out_data, 16'h8001);
        chk("t2_second_neg", bus.out_neg, 1);
        chk("t2_second_parity", bus.out_parity, 0);
        chk("t2_second_zero", bus.out_zero, 0);
        chk("t2_in_ready_back", bus.in_ready, 1);
        chk("t2_res_count_a", res_count, 2);
        @(negedge clk);
        chk("t2_empty", bus.out_valid, 0);
        chk("t2_res_count_b", res_count, 3);

        // Simultaneous push and pop in ONE
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00AA;
        bus.in_op     = OP_NOT;
        @(negedge clk);
        chk("t3_one_head", bus.out_data, 16'h00AA);
        bus.in_data   = 16'h1234;
        bus.in_op     = OP_AND;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_new_head", bus.out_data, 16'h1234);
        chk("t3_out_valid", bus.out_valid, 1);
        chk("t3_in_ready", bus.in_ready, 1);
        chk("t3_res_count", res_count, 4);

        // FULL ignores further in_valid
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h5555;
        bus.in_op     = OP_OR;
        @(negedge clk);
        bus.in_data = 16'hFFFF;
        bus.in_op   = OP_NOT;
        for (int i = 0; i < 3; i++) begin
            chk("t4_blocked_in_ready", bus.in_ready, 0);
            chk("t4_blocked_head", bus.out_data, 16'h1234);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_drain_second", bus.out_data, 16'h5555);
        chk("t4_drain_op", bus.out_op, OP_OR);
        @(negedge clk);
        chk("t4_drain_empty", bus.out_valid, 0);
        chk("t4_res_count", res_count, 6);

        // Stream up to 0xFFFF deliveries, then wrap
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0101;
        bus.in_op    = OP_XOR;
        repeat (65529) @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_res_count_max", res_count, 16'hFFFF);
        chk("t5_empty", bus.out_valid, 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0001;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_res_count_wrap", res_count, 16'h0000);

        // Async reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h7777;
        @(negedge clk);
        bus.in_data   = 16'h0F0F;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_data   = 16'h3C3C;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t6_full", bus.in_ready, 0);
        chk("t6_res_count_pre", res_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_in_ready", bus.in_ready, 1);
        chk("t6_rst_res_count", res_count, 0);
        chk("t6_rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00F0;
        bus.in_op     = OP_XOR;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t6_post_data", bus.out_data, 16'h00F0);
        chk("t6_post_op", bus.out_op, OP_XOR);
        chk("t6_post_parity", bus.out_parity, 0);
        @(negedge clk);
        chk("t6_post_res_count", res_count, 1);
        chk("t6_post_empty", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
